issue_ctl: RTL

ISSUE_CTL -- requirements
Module: issue_ctl

---
 rtl/issue_ctl_pkg.sv | 29 ++
 rtl/issue_ctl_if.sv | 33 +++
 rtl/issue_sb.sv | 61 ++++++
 rtl/issue_ctl.sv | 99 +++++++++
 4 files changed

// File: rtl/issue_ctl_pkg.sv
// -----------------------------------------------------------------------------
// issue_ctl_pkg
// Shared widths and types for the dual-slot issue controller and its
// register scoreboard.
//   REG_IDX_W   : register index width (5)
//   REG_NUM     : architectural register count (32)
//   LAT_W       : scoreboard countdown / result latency width (2)
//   STALL_CNT_W : stall cycle counter width (16)
// -----------------------------------------------------------------------------
package issue_ctl_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int REG_NUM     = 32;
  localparam int LAT_W       = 2;
  localparam int STALL_CNT_W = 16;

  typedef logic [REG_IDX_W-1:0]   reg_idx_t;
  typedef logic [LAT_W-1:0]       lat_t;
  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Per-cycle decision taken by the issue priority logic.
  typedef enum logic [1:0] {
    ACT_ISSUE  = 2'd0,
    ACT_STALL1 = 2'd1,
    ACT_STALL2 = 2'd2,
    ACT_SQUASH = 2'd3
  } issue_act_e;

endpackage

// File: rtl/issue_ctl_if.sv
// -----------------------------------------------------------------------------
// issue_ctl_if
// Fetch-unit <-> issue controller bundle.
//   fetch side (master) drives : VALID1/2, RD1/2, RSA1/2, RSB1/2, WE1/2,
//                                LAT1/2, JREQ
//   issue side (slave) drives  : STALL1, STALL2, ISSUE1, ISSUE2, STALL_CNT
// -----------------------------------------------------------------------------
interface issue_ctl_if;
  import issue_ctl_pkg::*;

  logic       VALID1, VALID2;
  reg_idx_t   RD1, RSA1, RSB1;
  reg_idx_t   RD2, RSA2, RSB2;
  logic       WE1, WE2;
  lat_t       LAT1, LAT2;
  logic       JREQ;
  logic       STALL1, STALL2;
  logic       ISSUE1, ISSUE2;
  stall_cnt_t STALL_CNT;

  modport master (
    output VALID1, VALID2, RD1, RSA1, RSB1, RD2, RSA2, RSB2,
           WE1, WE2, LAT1, LAT2, JREQ,
    input  STALL1, STALL2, ISSUE1, ISSUE2, STALL_CNT
  );

  modport slave (
    input  VALID1, VALID2, RD1, RSA1, RSB1, RD2, RSA2, RSB2,
           WE1, WE2, LAT1, LAT2, JREQ,
    output STALL1, STALL2, ISSUE1, ISSUE2, STALL_CNT
  );

endinterface

// File: rtl/issue_sb.sv
// -----------------------------------------------------------------------------
// issue_sb
// 32-entry register scoreboard holding a 2-bit countdown per register.
// Nonzero counts drain by one every cycle; a load port overrides the drain.
// Register 0 is never tracked.
// Configuration macro ISSUE_CTL_FWD_EN: when defined a count of 1 is treated
// as forwarded (not busy); otherwise any nonzero count is busy.
// Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   ld1_en/idx/lat      : slot 1 load port (wins over slot 2 on same index)
//   ld2_en/idx/lat      : slot 2 load port
//   q_idx[5:0]          : busy query indices {RD2,RSB2,RSA2,RD1,RSB1,RSA1}
//   q_busy[5:0]         : busy result for each query index
// -----------------------------------------------------------------------------
module issue_sb
  import issue_ctl_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  input  logic           ld1_en,
  input  reg_idx_t       ld1_idx,
  input  lat_t           ld1_lat,
  input  logic           ld2_en,
  input  reg_idx_t       ld2_idx,
  input  lat_t           ld2_lat,
  input  reg_idx_t [5:0] q_idx,
  output logic     [5:0] q_busy
);

  lat_t cnt [REG_NUM];

  function automatic logic is_busy(lat_t c);
`ifdef ISSUE_CTL_FWD_EN
    return (c >= lat_t'(2));
`else
    return (c != '0);
`endif
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < REG_NUM; i++) begin
        if (ld1_en && (ld1_idx == reg_idx_t'(i)))
          cnt[i] <= ld1_lat;
        else if (ld2_en && (ld2_idx == reg_idx_t'(i)))
          cnt[i] <= ld2_lat;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - lat_t'(1);
      end
    end
  end

  always_comb begin
    q_busy = '0;
    for (int q = 0; q < 6; q++) q_busy[q] = is_busy(cnt[q_idx[q]]);
  end

endmodule

// File: rtl/issue_ctl.sv
// -----------------------------------------------------------------------------
// issue_ctl
// Dual-slot in-order issue controller. Checks both fetch slots against the
// register scoreboard (issue_sb) and against each other, then decides to
// issue, stall both slots, issue slot 1 only, or squash on a taken jump.
// Configuration macro ISSUE_CTL_FWD_EN is consumed by issue_sb.
// Ports:
//   CLK  : clock
//   RST  : asynchronous active-high reset (clears scoreboard and STALL_CNT)
//   bus  : issue_ctl_if.slave -- slot inputs, JREQ, stall/issue outputs,
//          saturating STALL_CNT
// -----------------------------------------------------------------------------
module issue_ctl
  import issue_ctl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  issue_ctl_if.slave  bus
);

  reg_idx_t [5:0] q_idx;
  logic     [5:0] q_busy;
  logic           blk1, blk2, pair_hz;
  logic           ld1_en, ld2_en;
  logic           issue1, issue2, stall1, stall2;
  issue_act_e     act;
  stall_cnt_t     stall_cnt;

  function automatic stall_cnt_t sat_inc(stall_cnt_t v);
    return (v == '1) ? v : v + stall_cnt_t'(1);
  endfunction

  assign q_idx = {bus.RD2, bus.RSB2, bus.RSA2, bus.RD1, bus.RSB1, bus.RSA1};

  issue_sb u_sb (
    .CLK     (CLK),
    .RST     (RST),
    .ld1_en  (ld1_en),
    .ld1_idx (bus.RD1),
    .ld1_lat (bus.LAT1),
    .ld2_en  (ld2_en),
    .ld2_idx (bus.RD2),
    .ld2_lat (bus.LAT2),
    .q_idx   (q_idx),
    .q_busy  (q_busy)
  );

  // r0 never reads as busy because its scoreboard entry is held at zero.
  assign blk1 = bus.VALID1 & (q_busy[0] | q_busy[1] | (bus.WE1 & q_busy[2]));
  assign blk2 = bus.VALID2 & (q_busy[3] | q_busy[4] | (bus.WE2 & q_busy[5]));

  // Slot 2 may not consume or overwrite what slot 1 produces in the same cycle.
  assign pair_hz = bus.VALID1 & bus.VALID2 & bus.WE1 & (bus.RD1 != '0) &
                   ((bus.RD1 == bus.RSA2) | (bus.RD1 == bus.RSB2) |
                    (bus.RD1 == bus.RD2));

  always_comb begin
    act = ACT_ISSUE;
    if (bus.JREQ)                                 act = ACT_SQUASH;
    else if (blk1)                                act = ACT_STALL1;
    else if (!bus.VALID1 && blk2)                 act = ACT_STALL1;
    else if (bus.VALID1 && (blk2 || pair_hz))     act = ACT_STALL2;
  end

  always_comb begin
    stall1 = 1'b0;
    stall2 = 1'b0;
    issue1 = 1'b0;
    issue2 = 1'b0;
    case (act)
      ACT_STALL1: stall1 = 1'b1;
      ACT_STALL2: begin
        stall2 = 1'b1;
        issue1 = 1'b1;
      end
      ACT_ISSUE: begin
        issue1 = bus.VALID1;
        issue2 = bus.VALID2;
      end
      default: ;
    endcase
  end

  // LAT of 0 means the result needs no tracking.
  assign ld1_en = issue1 & bus.WE1 & (bus.RD1 != '0) & (bus.LAT1 != '0);
  assign ld2_en = issue2 & bus.WE2 & (bus.RD2 != '0) & (bus.LAT2 != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  stall_cnt <= '0;
    else if (stall1 | stall2) stall_cnt <= sat_inc(stall_cnt);
  end

  assign bus.STALL1    = stall1;
  assign bus.STALL2    = stall2;
  assign bus.ISSUE1    = issue1;
  assign bus.ISSUE2    = issue2;
  assign bus.STALL_CNT = stall_cnt;

endmodule
